// File: rtl/pc_next_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_ctrl
//  Description : IF-stage program-counter unit. Selects and registers the
//                next PC from sequential / branch / JAL / JR / HLT controls,
//                runs a BOOT/RUN/HALT FSM and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_next_ctrl #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_ctrl,
  input  logic [8:0]        br_offset,
  input  logic              jal,
  input  logic [11:0]       jal_offset,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              hlt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              fetch_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_retire;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_br_t;
  logic [ADDR_W-1:0] w_jal_t;

  // Candidate targets; all arithmetic wraps silently modulo 2^ADDR_W.
  assign w_seq   = r_pc + ADDR_W'(1);
  assign w_br_t  = w_seq + {{(ADDR_W-9){br_offset[8]}}, br_offset};
  assign w_jal_t = w_seq + {{(ADDR_W-12){jal_offset[11]}}, jal_offset};

  // Next-state, next-PC and retire decode; hlt > jr > jal > br > seq.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_retire    = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // One cycle to cover instruction-memory read latency.
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          w_retire = 1'b1;
          if (hlt) begin
            w_state_nxt = ST_HALT;
          end else if (jr) begin
            w_pc_nxt = jr_target;
          end else if (jal) begin
            w_pc_nxt = w_jal_t;
          end else if (br_ctrl) begin
            w_pc_nxt = w_br_t;
          end else begin
            w_pc_nxt = w_seq;
          end
        end
      end
      ST_HALT: begin
        // Only reset leaves HALT.
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_BOOT;
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  // Saturating retired-instruction count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_retire && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // State, PC and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign pc          = r_pc;
  assign pc_plus1    = w_seq;
  assign fetch_valid = (r_state == ST_RUN);
  assign halted      = (r_state == ST_HALT);
  assign instr_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_next_ctrl
//  Description : Directed self-checking bench for pc_next_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_next_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_ctrl;
  logic [8:0]  br_offset;
  logic        jal;
  logic [11:0] jal_offset;
  logic        jr;
  logic [15:0] jr_target;
  logic        hlt;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        fetch_valid;
  logic        halted;
  logic [15:0] instr_cnt;

  int n_tests;
  int n_fail;

  pc_next_ctrl #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .br_ctrl     (br_ctrl),
    .br_offset   (br_offset),
    .jal         (jal),
    .jal_offset  (jal_offset),
    .jr          (jr),
    .jr_target   (jr_target),
    .hlt         (hlt),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .instr_cnt   (instr_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts, and reports on mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall      = 1'b0;
    br_ctrl    = 1'b0;
    br_offset  = 9'h000;
    jal        = 1'b0;
    jal_offset = 12'h000;
    jr         = 1'b0;
    jr_target  = 16'h0000;
    hlt        = 1'b0;
  endtask

  // Redirect with JR (used to place pc at a chosen address).
  task automatic jump_to(input logic [15:0] tgt);
    idle_inputs();
    jr        = 1'b1;
    jr_target = tgt;
    tick();
    idle_inputs();
  endtask

  initial begin
    logic [31:0] rnd;
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    rst_n = 1'b0;

    // ---- 1: reset, BOOT, sequential fetch ----
    tick();
    tick();
    check("rst_pc", pc, 16'h0000);
    check("rst_pc_plus1", pc_plus1, 16'h0001);
    check("rst_fv", fetch_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_cnt", instr_cnt, 16'h0000);
    rst_n = 1'b1;
    // BOOT ignores controls: a JR presented now must not redirect.
    jr        = 1'b1;
    jr_target = 16'h0055;
    #1;
    check("boot_fv", fetch_valid, 1'b0);
    tick();
    idle_inputs();
    check("boot_pc", pc, 16'h0000);
    check("boot_cnt", instr_cnt, 16'h0000);
    check("run_fv", fetch_valid, 1'b1);
    tick();
    check("seq1_pc", pc, 16'h0001);
    check("seq1_cnt", instr_cnt, 16'h0001);
    tick();
    check("seq2_pc", pc, 16'h0002);
    check("seq2_cnt", instr_cnt, 16'h0002);
    tick();
    check("seq3_pc", pc, 16'h0003);
    check("seq3_cnt", instr_cnt, 16'h0003);

    // ---- 2: branch taken / not taken ----
    jump_to(16'h0010);
    check("jr10_pc", pc, 16'h0010);
    br_ctrl   = 1'b1;
    br_offset = 9'h1F8;
    tick();
    check("br_neg_pc", pc, 16'h0009);
    check("br_cnt", instr_cnt, 16'h0005);
    jump_to(16'h0010);
    br_ctrl   = 1'b0;
    br_offset = 9'h1F8;
    tick();
    check("br_nt_pc", pc, 16'h0011);
    br_ctrl   = 1'b1;
    br_offset = 9'h005;
    tick();
    check("br_pos_pc", pc, 16'h0017);

    // ---- 3: wrap-around, JAL, priorities ----
    jump_to(16'hFFFF);
    check("jrffff_pc_plus1", pc_plus1, 16'h0000);
    tick();
    check("wrap_pc", pc, 16'h0000);
    jump_to(16'h0002);
    jal        = 1'b1;
    jal_offset = 12'hFFC;
    #1;
    check("jal_link", pc_plus1, 16'h0003);
    tick();
    check("jal_pc", pc, 16'hFFFF);
    check("jal_cnt", instr_cnt, 16'h000C);
    idle_inputs();
    jr         = 1'b1;
    jr_target  = 16'h0100;
    jal        = 1'b1;
    jal_offset = 12'h005;
    tick();
    check("jr_over_jal", pc, 16'h0100);
    idle_inputs();
    jal        = 1'b1;
    jal_offset = 12'h010;
    br_ctrl    = 1'b1;
    br_offset  = 9'h001;
    tick();
    check("jal_over_br", pc, 16'h0111);
    check("prio_cnt", instr_cnt, 16'h000E);

    // ---- 5: stall holds PC and count, drops redirects ----
    idle_inputs();
    stall     = 1'b1;
    jr        = 1'b1;
    jr_target = 16'h1234;
    br_ctrl   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 16'h0111);
      check("stall_cnt", instr_cnt, 16'h000E);
      check("stall_fv", fetch_valid, 1'b1);
    end
    stall = 1'b0;
    tick();
    check("unstall_jr_pc", pc, 16'h1234);
    check("unstall_cnt", instr_cnt, 16'h000F);

    // ---- 6: asynchronous reset mid-cycle ----
    jump_to(16'h0040);
    check("at40_pc", pc, 16'h0040);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 16'h0000);
    check("arst_fv", fetch_valid, 1'b0);
    check("arst_cnt", instr_cnt, 16'h0000);
    #1;
    rst_n = 1'b1;
    tick();
    check("reboot_pc", pc, 16'h0000);
    check("reboot_fv", fetch_valid, 1'b1);
    tick();
    check("reboot_seq_pc", pc, 16'h0001);
    check("reboot_cnt", instr_cnt, 16'h0001);

    // ---- 4: HLT beats branch, then HALT ignores everything ----
    jump_to(16'h0020);
    hlt       = 1'b1;
    br_ctrl   = 1'b1;
    br_offset = 9'h010;
    tick();
    check("hlt_pc", pc, 16'h0020);
    check("hlt_halted", halted, 1'b1);
    check("hlt_fv", fetch_valid, 1'b0);
    check("hlt_cnt", instr_cnt, 16'h0003);
    for (int i = 0; i < 10; i++) begin
      rnd        = $urandom;
      stall      = rnd[0];
      br_ctrl    = rnd[1];
      jal        = rnd[2];
      jr         = rnd[3];
      hlt        = rnd[4];
      br_offset  = rnd[13:5];
      jal_offset = rnd[25:14];
      rnd        = $urandom;
      jr_target  = rnd[15:0];
      tick();
      check("halt_pc", pc, 16'h0020);
      check("halt_cnt", instr_cnt, 16'h0003);
      check("halt_halted", halted, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
